mem_bus_arbiter: RTL and testbench

- Shares a single SRAM-style memory bus between the instruction-fetch port and the data-memory port of the MEM stage.
- Grants one requester at a time and holds the bus until the memory acks or a watchdog expires.
- Returns read data with a one-cycle ready pulse and generates stall requests for the ctrl block.
- Sits between pc_reg/mem and the external memory.

---
 rtl/mem_bus_arbiter_pkg.sv | 6 +
 rtl/mem_bus_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_bus_arbiter.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg: state/owner encodings and defaults for the shared memory bus arbiter.
package mem_bus_arbiter_pkg;
  typedef enum logic [1:0] {ARB_IDLE = 2'd0, ARB_ACC = 2'd1, ARB_RESP = 2'd2} arb_state_t;
  typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_IF = 2'd1, OWN_MEM = 2'd2} arb_owner_t;
  localparam int ARB_TIMEOUT_DEFAULT = 16;
endpackage

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one SRAM-style bus between fetch and MEM ports, MEM has priority, watchdog aborts hung accesses.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT = ARB_TIMEOUT_DEFAULT,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic        if_ce_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_rdata_o,
  output logic        if_ready_o,
  input  logic        mem_ce_i,
  input  logic        mem_we_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  output logic [31:0] mem_rdata_o,
  output logic        mem_ready_o,
  output logic        bus_ce_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i,
  output logic        stallreq_if_o,
  output logic        stallreq_mem_o,
  output logic        bus_err_o
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);
  arb_state_t r_state, w_state;
  arb_owner_t r_owner, w_owner;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic r_discard, w_discard, r_ce, w_ce, r_we, w_we, r_err, w_err;
  logic [3:0] r_sel, w_sel;
  logic [31:0] r_addr, w_addr, r_wdata, w_wdata, r_if_rdata, w_if_rdata, r_mem_rdata, w_mem_rdata;
  logic w_drop, w_done;
  // a flush coinciding with the ack still drops the result
  assign w_drop = r_discard | flush_i;
  assign w_done = bus_ack_i | (r_cnt == LAST);
  always_comb begin
    w_state     = r_state;
    w_owner     = r_owner;
    w_cnt       = r_cnt;
    w_discard   = r_discard;
    w_ce        = r_ce;
    w_we        = r_we;
    w_sel       = r_sel;
    w_addr      = r_addr;
    w_wdata     = r_wdata;
    w_if_rdata  = r_if_rdata;
    w_mem_rdata = r_mem_rdata;
    w_err       = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        w_discard = 1'b0;
        if (!flush_i && (mem_ce_i || if_ce_i)) begin
          w_state = ARB_ACC;
          w_owner = mem_ce_i ? OWN_MEM : OWN_IF;
          w_cnt   = '0;
          w_ce    = 1'b1;
          w_we    = mem_ce_i & mem_we_i;
          w_sel   = mem_ce_i ? mem_sel_i : 4'hf;
          w_addr  = mem_ce_i ? mem_addr_i : if_addr_i;
          w_wdata = mem_ce_i ? mem_wdata_i : '0;
        end
      end
      ARB_ACC: begin
        w_cnt     = r_cnt + 1'b1;
        w_discard = w_drop;
        if (w_done) begin
          w_ce      = 1'b0;
          w_we      = 1'b0;
          w_sel     = '0;
          w_err     = !bus_ack_i;
          w_state   = w_drop ? ARB_IDLE : ARB_RESP;
          w_owner   = w_drop ? OWN_NONE : r_owner;
          w_discard = 1'b0;
          if (!w_drop && r_owner == OWN_IF) w_if_rdata = bus_ack_i ? bus_rdata_i : '0;
          if (!w_drop && r_owner == OWN_MEM) w_mem_rdata = bus_ack_i ? bus_rdata_i : '0;
        end
      end
      ARB_RESP: begin
        w_state   = ARB_IDLE;
        w_owner   = OWN_NONE;
        w_discard = 1'b0;
      end
      default: w_state = ARB_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ARB_IDLE;
      r_owner     <= OWN_NONE;
      r_cnt       <= '0;
      r_discard   <= 1'b0;
      r_ce        <= 1'b0;
      r_we        <= 1'b0;
      r_sel       <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_if_rdata  <= '0;
      r_mem_rdata <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_owner     <= w_owner;
      r_cnt       <= w_cnt;
      r_discard   <= w_discard;
      r_ce        <= w_ce;
      r_we        <= w_we;
      r_sel       <= w_sel;
      r_addr      <= w_addr;
      r_wdata     <= w_wdata;
      r_if_rdata  <= w_if_rdata;
      r_mem_rdata <= w_mem_rdata;
      r_err       <= w_err;
    end
  end
  assign bus_ce_o       = r_ce;
  assign bus_we_o       = r_we;
  assign bus_sel_o      = r_sel;
  assign bus_addr_o     = r_addr;
  assign bus_wdata_o    = r_wdata;
  assign bus_err_o      = r_err;
  assign if_rdata_o     = r_if_rdata;
  assign mem_rdata_o    = r_mem_rdata;
  assign if_ready_o     = (r_state == ARB_RESP) && (r_owner == OWN_IF);
  assign mem_ready_o    = (r_state == ARB_RESP) && (r_owner == OWN_MEM);
  assign stallreq_if_o  = if_ce_i && !if_ready_o;
  assign stallreq_mem_o = mem_ce_i && !mem_ready_o;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: transaction scoreboard for mem_bus_arbiter with a scripted memory responder.
module tb_mem_bus_arbiter;
  localparam int TO = 6;
  typedef struct {
    int rise, len, lat;
    bit port_mem, drop, to, we;
    logic [3:0] sel;
    logic [31:0] addr, wdata, rdata;
  } item_t;
  logic clk, rst, flush_i, if_ce_i, if_ready_o, mem_ce_i, mem_we_i, mem_ready_o;
  logic bus_ce_o, bus_we_o, bus_ack_i, stallreq_if_o, stallreq_mem_o, bus_err_o;
  logic [3:0] mem_sel_i, bus_sel_o;
  logic [31:0] if_addr_i, if_rdata_o, mem_addr_i, mem_wdata_i, mem_rdata_o, bus_addr_o, bus_wdata_o, bus_rdata_i;
  item_t items[$];
  int rq_d[$];
  logic [31:0] rq_rd[$];
  int cyc = 0, free_cyc = 0, vectors = 0, miscompares = 0;
  mem_bus_arbiter #(.TIMEOUT(TO), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .if_ce_i(if_ce_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_ready_o(if_ready_o),
    .mem_ce_i(mem_ce_i), .mem_we_i(mem_we_i), .mem_sel_i(mem_sel_i), .mem_addr_i(mem_addr_i),
    .mem_wdata_i(mem_wdata_i), .mem_rdata_o(mem_rdata_o), .mem_ready_o(mem_ready_o),
    .bus_ce_o(bus_ce_o), .bus_we_o(bus_we_o), .bus_sel_o(bus_sel_o), .bus_addr_o(bus_addr_o),
    .bus_wdata_o(bus_wdata_o), .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i),
    .stallreq_if_o(stallreq_if_o), .stallreq_mem_o(stallreq_mem_o), .bus_err_o(bus_err_o)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, exp);
    end
  endtask
  // memory model: acks d cycles into each access (never when d >= TO), returning the scripted word
  initial begin
    int k, dd;
    logic [31:0] rr;
    logic prev;
    k = 0; dd = 0; rr = '0; prev = 1'b0;
    bus_ack_i = 1'b0;
    bus_rdata_i = '0;
    forever begin
      @(posedge clk); #1;
      if (bus_ce_o === 1'b1 && !prev) begin
        chk("resp_queue_nonempty", 32'(rq_d.size() != 0), 32'd1);
        if (rq_d.size() != 0) begin
          dd = rq_d.pop_front();
          rr = rq_rd.pop_front();
        end
        k = 0;
      end
      bus_ack_i = (bus_ce_o === 1'b1) && (k == dd);
      bus_rdata_i = bus_ack_i ? rr : $urandom;
      if (bus_ce_o === 1'b1) k++;
      prev = (bus_ce_o === 1'b1);
    end
  end
  // monitor: expected outputs each cycle from the transaction schedule
  initial begin
    item_t cur;
    bit have, rst_e, exp_ce, rdy, exp_ifr, exp_memr, exp_err;
    logic [31:0] exp_if, exp_mem;
    have = 0; exp_if = '0; exp_mem = '0;
    forever begin
      @(posedge clk);
      cyc++;
      rst_e = rst;
      @(negedge clk);
      if (items.size() > 0 && items[0].rise == cyc) begin
        cur = items.pop_front();
        have = 1;
      end
      exp_ce = have && cyc < cur.rise + cur.len;
      rdy = have && !cur.drop && cyc == cur.rise + cur.lat;
      exp_ifr = rdy && !cur.port_mem;
      exp_memr = rdy && cur.port_mem;
      exp_err = rdy && cur.to;
      if (rst_e) begin
        exp_if = '0;
        exp_mem = '0;
        chk("rst_bus_we", 32'(bus_we_o), 0);
        chk("rst_bus_sel", 32'(bus_sel_o), 0);
        chk("rst_bus_addr", bus_addr_o, 0);
        chk("rst_bus_wdata", bus_wdata_o, 0);
        exp_ce = 0; exp_ifr = 0; exp_memr = 0; exp_err = 0;
      end
      if (exp_ifr) exp_if = cur.rdata;
      if (exp_memr) exp_mem = cur.rdata;
      chk("bus_ce", 32'(bus_ce_o), 32'(exp_ce));
      chk("if_ready", 32'(if_ready_o), 32'(exp_ifr));
      chk("mem_ready", 32'(mem_ready_o), 32'(exp_memr));
      chk("bus_err", 32'(bus_err_o), 32'(exp_err));
      chk("if_rdata", if_rdata_o, exp_if);
      chk("mem_rdata", mem_rdata_o, exp_mem);
      chk("stall_if", 32'(stallreq_if_o), 32'(if_ce_i && !exp_ifr));
      chk("stall_mem", 32'(stallreq_mem_o), 32'(mem_ce_i && !exp_memr));
      if (exp_ce) begin
        chk("bus_addr", bus_addr_o, cur.addr);
        chk("bus_we", 32'(bus_we_o), 32'(cur.we));
        chk("bus_sel", 32'(bus_sel_o), 32'(cur.sel));
        chk("bus_wdata", bus_wdata_o, cur.wdata);
      end
    end
  end
  function automatic item_t mk(input bit pm, input bit we, input logic [3:0] sel, input logic [31:0] addr,
                               input logic [31:0] wd, input logic [31:0] rd, input int d, input int rise);
    item_t t;
    t.port_mem = pm;
    t.we = pm & we;
    t.sel = pm ? sel : 4'hf;
    t.addr = addr;
    t.wdata = pm ? wd : '0;
    t.rise = rise;
    t.to = d >= TO;
    t.lat = t.to ? TO : d + 1;
    t.len = t.lat;
    t.drop = 0;
    t.rdata = t.to ? '0 : rd;
    return t;
  endfunction
  // fk: 0 none, 1 flush while idle with request, 2 flush f cycles into access, 3 flush in response cycle
  task automatic txn(input bit both, input bit mem_p, input bit we_in, input logic [3:0] sel_in,
                     input logic [31:0] addr_in, input logic [31:0] wd_in, input logic [31:0] rd_in,
                     input int d, input int fk, input int f, input bit do_rst);
    item_t a, b;
    int q, fl, if_off, mem_off, rst_on, d2;
    logic [31:0] rd2;
    while (cyc < free_cyc) begin
      @(posedge clk); #1;
    end
    q = cyc;
    a = mk(both | mem_p | do_rst, we_in, sel_in, addr_in, wd_in, rd_in, d, q + 1 + ((fk == 1) ? 1 : 0));
    a.drop = (fk == 2) || do_rst;
    if (do_rst) a.len = 3;
    fl = (fk == 1) ? q : (fk == 2) ? a.rise + f : (fk == 3) ? a.rise + a.lat : -1;
    free_cyc = a.drop ? a.rise + d + 1 : a.rise + a.lat + 1;
    mem_off = (fk == 2) ? fl : a.rise + a.lat;
    if_off = mem_off;
    rst_on = do_rst ? a.rise + 2 : -1;
    items.push_back(a);
    rq_d.push_back(d);
    rq_rd.push_back(rd_in);
    if (both || do_rst) begin
      d2 = $urandom_range(0, TO - 1);
      rd2 = $urandom;
      if (both) b = mk(0, 0, 4'hf, $urandom, '0, rd2, d2, free_cyc + 1);
      else b = mk(1, we_in, sel_in, addr_in, wd_in, rd2, d2, a.rise + 4);
      items.push_back(b);
      rq_d.push_back(d2);
      rq_rd.push_back(rd2);
      if (both) if_off = b.rise + b.lat;
      else mem_off = b.rise + b.lat;
      free_cyc = b.rise + b.lat + 1;
    end
    if (a.port_mem) begin
      mem_ce_i = 1; mem_we_i = we_in; mem_sel_i = sel_in; mem_addr_i = addr_in; mem_wdata_i = wd_in;
    end
    if (!a.port_mem || both) begin
      if_ce_i = 1;
      if_addr_i = both ? b.addr : addr_in;
    end
    flush_i = (fl == q);
    while (cyc < free_cyc) begin
      @(posedge clk); #1;
      flush_i = (cyc == fl);
      rst = (cyc == rst_on);
      if (cyc == mem_off) mem_ce_i = 0;
      if (cyc == if_off) if_ce_i = 0;
    end
  endtask
  initial begin
    rst = 1; flush_i = 0; if_ce_i = 0; if_addr_i = '0; mem_ce_i = 0; mem_we_i = 0;
    mem_sel_i = '0; mem_addr_i = '0; mem_wdata_i = '0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    txn(0, 0, 0, 4'hf, 32'h100, '0, 32'h3C010001, 0, 0, 0, 0);
    txn(1, 1, 1, 4'hf, 32'h200, 32'hDEADBEEF, 32'h0BADF00D, 0, 0, 0, 0);
    txn(0, 1, 0, 4'h3, 32'h300, '0, 32'hCAFEF00D, TO - 1, 0, 0, 0);
    txn(0, 1, 0, 4'hf, 32'h400, '0, 32'h11111111, TO, 0, 0, 0);
    txn(0, 0, 0, 4'hf, 32'h500, '0, 32'h22222222, 2, 2, 0, 0);
    txn(0, 1, 0, 4'hf, 32'h600, '0, 32'h33333333, 3, 2, 3, 0);
    txn(0, 0, 0, 4'hf, 32'h700, '0, 32'h44444444, 1, 1, 0, 0);
    txn(0, 1, 1, 4'h1, 32'h800, 32'h55, 32'h66666666, 1, 3, 0, 0);
    txn(0, 1, 1, 4'hc, 32'h900, 32'h77, 32'h88888888, 255, 0, 0, 1);
    for (int i = 0; i < 80; i++) begin
      int d, fk, f;
      d = $urandom_range(0, TO + 1);
      fk = $urandom_range(0, 3);
      if (fk == 2 && d >= TO) fk = 0;
      f = (fk == 2) ? $urandom_range(0, d) : 0;
      txn($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom),
          $urandom, $urandom, $urandom, d, fk, f, 0);
    end
    repeat (4) @(posedge clk);
    #1;
    chk("items_drained", 32'(items.size()), 0);
    chk("resp_drained", 32'(rq_d.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL sim_time_limit reached without completion");
    $fatal(1);
  end
endmodule
